// File: rtl/ift_boot_rom_bridge.sv
// ift_boot_rom_bridge
//
// Purpose: request/response bridge in front of the taint-tracked boot ROM.
// Word requests arrive on a req/gnt channel. Hit reads drive the ROM
// chip-select in the acceptance cycle. The ROM's registered data and data taint
// are captured one cycle later into a small response FIFO. Writes and
// out-of-window addresses get an error response and never touch the ROM.
//
// Handshakes:
//   request  : a request transfers on a clock edge where req_i && gnt_o.
//   response : a response transfers on a clock edge where r_valid_o && r_ready_i.
//              While r_valid_o && !r_ready_i, the response fields hold steady.
//
// Optional feature: when IFT_BOOTROM_ADDR_TAINT_EN is defined, hit-read data
// taint also picks up the taint of the word index and of req_i.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   req_i, addr_i, we_i, be_i      request (be_i is ignored)
//   gnt_o                          request accepted
//   r_valid_o, r_ready_i           response handshake
//   r_rdata_o, r_err_o             response data (0 on error), error flag
//   rom_csn_o, rom_add_o           ROM chip select (active-low), address
//   rom_wen_o, rom_be_o            ROM write enable / byte enables, tied off
//   rom_rdata_i                    ROM registered read data
//   req_i_t0, addr_i_t0, we_i_t0   input taints
//   rom_rdata_i_t0                 ROM data taint
//   rom_add_o_t0                   address taint on accepted reads
//   r_rdata_o_t0, r_err_o_t0       response taints
module ift_boot_rom_bridge #(
    parameter logic [31:0] AddrOffset   = 32'h1A000000,
    parameter int unsigned RomAddrWidth = 13,
    parameter int unsigned FifoDepth    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        r_valid_o,
    input  logic        r_ready_i,
    output logic [31:0] r_rdata_o,
    output logic        r_err_o,
    output logic        rom_csn_o,
    output logic [31:0] rom_add_o,
    output logic        rom_wen_o,
    output logic [31:0] rom_be_o,
    input  logic [31:0] rom_rdata_i,
    input  logic        req_i_t0,
    input  logic [31:0] addr_i_t0,
    input  logic        we_i_t0,
    input  logic [31:0] rom_rdata_i_t0,
    output logic [31:0] rom_add_o_t0,
    output logic [31:0] r_rdata_o_t0,
    output logic        r_err_o_t0
);

    localparam int unsigned PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW    = $clog2(FifoDepth) + 1;
    localparam logic [31:0] WinSize = 32'd1 << RomAddrWidth;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    logic [31:0] offset_addr;
    logic        hit;
    logic        accept;
    logic        rd_hit;
    logic        push;
    logic        pop;

    // Addresses below the window base wrap to large offsets and miss.
    assign offset_addr = addr_i - AddrOffset;
    assign hit         = (offset_addr < WinSize);
    assign accept      = req_i && gnt_o;
    assign rd_hit      = accept && !we_i && hit;

    assign rom_csn_o    = !rd_hit;
    assign rom_add_o    = addr_i;
    assign rom_wen_o    = 1'b1;
    assign rom_be_o     = 32'hFFFF_FFFF;
    assign rom_add_o_t0 = (accept && !we_i) ? addr_i_t0 : 32'h0;

    // ------------------------------------------------------------------
    // Stage s1: one request waiting for its ROM data
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s1_err_q,   s1_err_d;
    logic s1_err_t_q, s1_err_t_d;
    logic s1_idx_t_q, s1_idx_t_d;
    logic unused_inputs;

`ifdef IFT_BOOTROM_ADDR_TAINT_EN
    // A tainted word index (or request) taints the whole returned word.
    assign s1_idx_t_d    = (|addr_i_t0[RomAddrWidth-1:2]) | req_i_t0;
    assign unused_inputs = ^be_i;
`else
    assign s1_idx_t_d    = 1'b0;
    assign unused_inputs = ^{be_i, req_i_t0};
`endif

    assign s1_valid_d = accept;
    assign s1_err_d   = accept && (we_i || !hit);
    assign s1_err_t_d = accept && ((|addr_i_t0) | we_i_t0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_err_t_q <= 1'b0;
            s1_idx_t_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_err_t_q <= s1_err_t_d;
            s1_idx_t_q <= s1_idx_t_d;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [31:0]     data_mem  [FifoDepth];
    logic [31:0]     taint_mem [FifoDepth];
    logic            err_mem   [FifoDepth];
    logic            errt_mem  [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q,  count_d;
    logic [CntW:0]   credit_use;
    logic [31:0]     push_data;
    logic [31:0]     push_taint;

    assign push       = s1_valid_q;
    assign pop        = r_valid_o && r_ready_i;
    assign push_data  = s1_err_q ? 32'h0 : rom_rdata_i;
    assign push_taint = s1_err_q ? 32'h0 : (rom_rdata_i_t0 | {32{s1_idx_t_q}});

    // Occupancy after this cycle if everything in flight lands; a same-cycle
    // pop frees a slot so an always-ready consumer sustains one per cycle.
    assign credit_use = (CntW+1)'(count_q) + (CntW+1)'(s1_valid_q) - (CntW+1)'(pop);
    assign gnt_o      = !rst_i && (credit_use < (CntW+1)'(FifoDepth));

    assign wr_ptr_d = push ? PtrW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? PtrW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    assign count_d  = count_q + CntW'(push) - CntW'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are gated by r_valid_o.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            data_mem[wr_ptr_q]  <= push_data;
            taint_mem[wr_ptr_q] <= push_taint;
            err_mem[wr_ptr_q]   <= s1_err_q;
            errt_mem[wr_ptr_q]  <= s1_err_t_q;
        end
    end

    assign r_valid_o    = (count_q != '0);
    assign r_rdata_o    = r_valid_o ? data_mem[rd_ptr_q]  : 32'h0;
    assign r_rdata_o_t0 = r_valid_o ? taint_mem[rd_ptr_q] : 32'h0;
    assign r_err_o      = r_valid_o && err_mem[rd_ptr_q];
    assign r_err_o_t0   = r_valid_o && errt_mem[rd_ptr_q];

endmodule

// File: tb/tb_ift_boot_rom_bridge.sv
module tb_ift_boot_rom_bridge;

    localparam int FifoDepth = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        r_valid_o;
    logic        r_ready_i;
    logic [31:0] r_rdata_o;
    logic        r_err_o;
    logic        rom_csn_o;
    logic [31:0] rom_add_o;
    logic        rom_wen_o;
    logic [31:0] rom_be_o;
    logic [31:0] rom_rdata_i;
    logic        req_i_t0;
    logic [31:0] addr_i_t0;
    logic        we_i_t0;
    logic [31:0] rom_rdata_i_t0;
    logic [31:0] rom_add_o_t0;
    logic [31:0] r_rdata_o_t0;
    logic        r_err_o_t0;

    ift_boot_rom_bridge #(.FifoDepth(FifoDepth)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .r_rdata_o(r_rdata_o), .r_err_o(r_err_o), .rom_csn_o(rom_csn_o),
        .rom_add_o(rom_add_o), .rom_wen_o(rom_wen_o), .rom_be_o(rom_be_o),
        .rom_rdata_i(rom_rdata_i), .req_i_t0(req_i_t0), .addr_i_t0(addr_i_t0),
        .we_i_t0(we_i_t0), .rom_rdata_i_t0(rom_rdata_i_t0),
        .rom_add_o_t0(rom_add_o_t0), .r_rdata_o_t0(r_rdata_o_t0),
        .r_err_o_t0(r_err_o_t0)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ROM model ----------------
    logic [31:0] mem  [2048];
    logic [31:0] tmem [2048];

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]  = 32'hC0DE_0000 | 32'(i * 3);
            tmem[i] = 32'h0;
        end
        mem[4]     = 32'hDEADBEEF;
        tmem[4]    = 32'h000000FF;
        tmem[1]    = 32'h00F00000;
        tmem[2047] = 32'h80000001;
    end

    // Registered read; non-selected cycles return junk so a leak shows up.
    always @(posedge clk) begin
        if (!rom_csn_o) begin
            rom_rdata_i    <= mem[rom_add_o[12:2]];
            rom_rdata_i_t0 <= tmem[rom_add_o[12:2]];
        end else begin
            rom_rdata_i    <= 32'hBAD0BAD0;
            rom_rdata_i_t0 <= 32'hFFFF0000;
        end
    end

    // ---------------- scoreboard ----------------
    // entry = {data[31:0], taint[31:0], err, err_taint}
    logic [65:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic        last_csn;
    logic [31:0] last_add_t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [65:0] expect_resp(input logic [31:0] a, input logic w,
                                                input logic [31:0] at, input logic wt,
                                                input logic rt);
        logic [31:0] offs;
        logic [31:0] mask;
        logic        et;
        offs = a - 32'h1A000000;
        et   = (|at) | wt;
        if (w || offs >= 32'h2000) return {32'h0, 32'h0, 1'b1, et};
        mask = 32'h0;
`ifdef IFT_BOOTROM_ADDR_TAINT_EN
        mask = {32{(|at[12:2]) | rt}};
`else
        if (rt) mask = 32'h0;
`endif
        return {mem[a[12:2]], tmem[a[12:2]] | mask, 1'b0, et};
    endfunction

    // Monitor: pops on every response transfer.
    always @(negedge clk) begin
        logic [65:0] e;
        if (!rst_i && r_valid_o && r_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got data %h err %0b expected none", r_rdata_o, r_err_o);
            end else begin
                e = exp_q.pop_front();
                check("r_rdata", r_rdata_o, e[65:34]);
                check("r_rdata_t0", r_rdata_o_t0, e[33:2]);
                check("r_err", 32'(r_err_o), 32'(e[1]));
                check("r_err_t0", 32'(r_err_o_t0), 32'(e[0]));
            end
        end
        if (!rst_i && !r_valid_o && r_rdata_o_t0 !== 32'h0)
            check("idle_rdata_t0", r_rdata_o_t0, 32'h0);
        if (dut.push && dut.count_q == 2'(FifoDepth) && !dut.pop)
            check("push_full", 32'(dut.count_q), 32'(FifoDepth - 1));
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge
    // with the request still asserted.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] at,
                         input logic wt, input logic rt, output int waited);
        req_i = 1'b1; addr_i = a; we_i = w; addr_i_t0 = at; we_i_t0 = wt;
        req_i_t0 = rt; be_i = 4'hF;
        waited = 0;
        while (1) begin
            @(negedge clk);
            if (gnt_o) begin
                last_csn    = rom_csn_o;
                last_add_t0 = rom_add_o_t0;
                exp_q.push_back(expect_resp(a, w, at, wt, rt));
                @(posedge clk); #1;
                break;
            end
            waited++;
            if (waited > 50) begin
                check("gnt_timeout", 32'(waited), 32'd0);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        req_i = 1'b0; we_i = 1'b0; addr_i_t0 = 32'h0; we_i_t0 = 1'b0; req_i_t0 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int grants;
        logic [31:0] held;
        rst_i = 1'b1; req_i = 1'b1; addr_i = 32'h1A000010; we_i = 1'b0; be_i = 4'hF;
        r_ready_i = 1'b1; req_i_t0 = 1'b0; addr_i_t0 = 32'h0; we_i_t0 = 1'b0;

        // Reset hold with a pending request.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_csn", 32'(rom_csn_o), 32'd1);
        check("rst_valid", 32'(r_valid_o), 32'd0);
        check("rst_rdata", r_rdata_o, 32'h0);
        check("rst_err", 32'(r_err_o), 32'd0);
        check("rst_rdata_t0", r_rdata_o_t0, 32'h0);
        check("rst_err_t0", 32'(r_err_o_t0), 32'd0);
        check("rst_add_t0", rom_add_o_t0, 32'h0);
        @(posedge clk); #1;
        rst_i = 1'b0; req_i = 1'b0;

        // Single read with latency check.
        issue(32'h1A000010, 1'b0, 32'h0, 1'b0, 1'b0, w);
        check("single_csn", 32'(last_csn), 32'd0);
        req_i = 1'b0;
        @(negedge clk);
        check("lat_n1_valid", 32'(r_valid_o), 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat_n2_valid", 32'(r_valid_o), 32'd1);
        @(posedge clk); #1;
        idle(2);

        // Back-to-back reads, consumer always ready.
        for (int i = 0; i < 4; i++) begin
            issue(32'h1A000000 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0, w);
            check("b2b_gnt_wait", 32'(w), 32'd0);
        end
        idle(5);

        // Backpressure: exactly FifoDepth grants while stalled.
        r_ready_i = 1'b0;
        grants = 0;
        held = 32'h0;
        for (int c = 0; c < 6; c++) begin
            req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A000020 + 32'(4 * grants);
            @(negedge clk);
            if (gnt_o) begin
                exp_q.push_back(expect_resp(addr_i, 1'b0, 32'h0, 1'b0, 1'b0));
                grants++;
            end
            if (c == 4) held = r_rdata_o;
            if (c == 5) check("bp_stable", r_rdata_o, held);
            @(posedge clk); #1;
        end
        check("bp_grants", 32'(grants), 32'(FifoDepth));
        r_ready_i = 1'b1;
        issue(32'h1A000040, 1'b0, 32'h0, 1'b0, 1'b0, w);
        check("bp_resume_wait", 32'(w), 32'd0);
        issue(32'h1A000004, 1'b0, 32'h0, 1'b0, 1'b0, w);
        idle(5);

        // Error responses and window boundaries.
        issue(32'h1A000000, 1'b1, 32'h0, 1'b1, 1'b0, w);
        check("wr_csn", 32'(last_csn), 32'd1);
        issue(32'h1A002000, 1'b0, 32'h0, 1'b0, 1'b0, w);
        check("miss_hi_csn", 32'(last_csn), 32'd1);
        issue(32'h19FFFFFC, 1'b0, 32'h0, 1'b0, 1'b0, w);
        check("miss_lo_csn", 32'(last_csn), 32'd1);
        issue(32'h1A001FFC, 1'b0, 32'h0, 1'b0, 1'b0, w);
        check("last_word_csn", 32'(last_csn), 32'd0);
        idle(5);

        // Address / request taint.
        issue(32'h1A00000C, 1'b0, 32'h4, 1'b0, 1'b0, w);
        check("add_o_t0", last_add_t0, 32'h4);
        issue(32'h1A000008, 1'b0, 32'h0, 1'b0, 1'b1, w);
        issue(32'h1A000014, 1'b0, 32'h1, 1'b0, 1'b0, w);
        idle(5);

        // Reset with one FIFO entry and one read in s1: both dropped.
        r_ready_i = 1'b0;
        issue(32'h1A000004, 1'b0, 32'h0, 1'b0, 1'b0, w);
        issue(32'h1A000008, 1'b0, 32'h0, 1'b0, 1'b0, w);
        rst_i = 1'b1;
        req_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_gnt", 32'(gnt_o), 32'd0);
        check("midrst_csn", 32'(rom_csn_o), 32'd1);
        @(posedge clk); #1;
        rst_i = 1'b0;
        req_i = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(r_valid_o), 32'd0);
        @(posedge clk); #1;
        r_ready_i = 1'b1;
        idle(6);
        issue(32'h1A001FFC, 1'b0, 32'h0, 1'b0, 1'b0, w);
        idle(5);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ift_boot_rom_bridge.md
# ift_boot_rom_bridge

Request/response bridge sitting directly upstream of the taint-tracked boot ROM. It accepts word requests from the SoC interconnect (req/gnt, r_valid/r_ready), drives the ROM's chip-select/address pins, and captures the ROM's registered read data and data taint one cycle later. Results go into a small response FIFO, so the interconnect can apply backpressure without losing ROM output. Writes and out-of-window addresses are answered with an error response, so the ROM's own write pins are never exercised.

## Interface
Parameters:
- AddrOffset, 32'h1A000000, base of the ROM window in the address map
- RomAddrWidth, 13, byte-address bits decoded by the ROM; window size = 2^RomAddrWidth bytes
- FifoDepth, 2, response FIFO entries (power of two, >= 2)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  request valid
- addr_i  in  32  byte address
- we_i  in  1  write request (always rejected)
- be_i  in  4  byte enables (ignored for reads)
- gnt_o  out  1  request accepted this cycle when req_i && gnt_o
- r_valid_o  out  1  response valid
- r_ready_i  in  1  response consumed when r_valid_o && r_ready_i
- r_rdata_o  out  32  response data (0 on error)
- r_err_o  out  1  error response
- rom_csn_o  out  1  ROM chip select, active-low
- rom_add_o  out  32  ROM address (addr_i passed through)
- rom_wen_o  out  1  ROM write enable, tied 1 (read)
- rom_be_o  out  32  tied 32'hFFFF_FFFF
- rom_rdata_i  in  32  ROM registered read data
- req_i_t0, addr_i_t0 (32), we_i_t0  in  taints of the matching inputs
- rom_rdata_i_t0  in  32  ROM data taint
- rom_add_o_t0  out  32  = addr_i_t0 on accepted reads, else 0
- r_rdata_o_t0  out  32  response data taint
- r_err_o_t0  out  1  response error taint

## Operation
- Window hit: (addr_i - AddrOffset) < 2^RomAddrWidth, computed as an unsigned 32-bit subtraction; addr_i below AddrOffset wraps and misses.
- Accepted read with hit: rom_csn_o=0 in the same cycle. One-entry pipeline stage s1 records {valid, err=0}.
- Accepted write or miss: rom_csn_o stays 1. s1 records {valid, err=1}.
- Cycle after acceptance: if s1.valid, push {rdata, err, taints} into the FIFO.
  - err=0: rdata=rom_rdata_i, taint=rom_rdata_i_t0.
  - err=1: rdata=0, taint=0.
- Response outputs are the FIFO head. Pop on r_valid_o && r_ready_i. Responses return strictly in request order.
- Credit rule: gnt_o = !rst_i && (fifo_count + s1.valid - pop) < FifoDepth. Pop in the same cycle frees a slot, so a consumer that is always ready sees one request per cycle.
- Push into a full FIFO is impossible by the credit rule. The bench asserts that it never occurs.
- Error taint: r_err_o_t0 = (|addr_i_t0) | we_i_t0, sampled at acceptance and carried through s1 and the FIFO.
- r_rdata_o_t0 = 0 whenever r_valid_o=0.

## Timing
- Reset (rst_i=1 at a clock edge): FIFO emptied, s1 cleared. r_valid_o=0, r_rdata_o=0, r_err_o=0, all _t0 outputs 0.
- During reset: gnt_o=0, rom_csn_o=1.
- Reset mid-operation: an in-flight ROM read in s1 is discarded. Unread FIFO entries are dropped with no response.
- Latency: request accepted in cycle N -> ROM data arrives N+1 -> r_valid_o=1 in N+2 at the earliest. Errors have identical latency.
- Throughput: 1 response/cycle when r_ready_i is held 1.
- r_valid_o and the response fields stay stable while r_valid_o && !r_ready_i.
- FIFO pointers wrap modulo FifoDepth. Full and empty are distinguished by an occupancy counter of width clog2(FifoDepth)+1.

## Configuration
- IFT_BOOTROM_ADDR_TAINT_EN defined: on hit reads, the pushed data taint = rom_rdata_i_t0 | {32{(|addr_i_t0[RomAddrWidth-1:2]) | req_i_t0}}, with addr_i_t0 and req_i_t0 sampled at acceptance. A tainted index therefore taints the whole word.
- Not defined: data taint = rom_rdata_i_t0 only. Address taint reaches only rom_add_o_t0 and r_err_o_t0.

## Test plan
- Reset hold: rst_i=1 with req_i=1 -> gnt_o=0, rom_csn_o=1, r_valid_o=0, all outputs 0.
- Single read addr_i=32'h1A000010, ROM returns 32'hDEADBEEF with taint 32'h000000FF -> r_valid_o in N+2 with r_rdata_o=32'hDEADBEEF, r_rdata_o_t0=32'h000000FF, r_err_o=0.
- Back-to-back reads 0x1A000000..0x1A00000C with r_ready_i=1 -> gnt_o=1 every cycle, 4 in-order responses on consecutive cycles.
- Backpressure r_ready_i=0 for 6 cycles with req_i=1 -> exactly FifoDepth grants. On release, responses drain in order and gnt_o resumes.
- Write to 0x1A000000 and read of 0x1A002000 -> rom_csn_o stays 1, r_err_o=1, r_rdata_o=0. With we_i_t0=1: r_err_o_t0=1.
- addr_i_t0=32'h4 on a hit read with untainted ROM data -> r_rdata_o_t0=32'hFFFFFFFF with IFT_BOOTROM_ADDR_TAINT_EN, 0 without. Also: reset asserted while s1.valid=1 -> no response emitted afterward.
